usb_linestate_mon: RTL
======================

# usb_linestate_mon

Parametrised USB full-speed bus-condition monitor that tracks bus reset, suspend and resume, and Start-Of-Frame health from PHY line state and the RX packet decoder. Sits beside `usb_trans`/`usb_rx_pkt` in the USB core and replaces the fixed reset/suspend timers and single SOF pending bit. Adds configurable thresholds, resume detection, a frame-number continuity check and a lost-SOF watchdog. Sticky per-event pending bits drive one maskable interrupt for the CSR block.

## Interface
- `RESET_CYC`, 120: consecutive SE0 cycles that declare bus reset (2.5 µs at 48 MHz).
- `SUSPEND_CYC`, 144000: consecutive idle-J cycles that declare suspend (3 ms at 48 MHz).
- `SOF_TMO_CYC`, 72000: cycles without SOF, while ACTIVE, that count one missed SOF.
- `CNT_W`, `$clog2(SUSPEND_CYC+1)`: auto-set timer width.
- Legal only with `RESET_CYC` < `SUSPEND_CYC` and `SOF_TMO_CYC` ≤ `SUSPEND_CYC`.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rx_dp`, `rx_dn`  in  1 each  synchronised line state from `usb_phy`.
- `tx_active`  in  1  PHY driving; suspends idle counting.
- `sof_stb`  in  1  one-cycle pulse, valid SOF received.
- `sof_frameno`  in  11  frame number, valid with `sof_stb`.
- `evt_clr`  in  5  write-1-to-clear strobes for `evt_pend`.
- `irq_mask`  in  5  per-event interrupt enable.
- `usb_reset`  out  1  bus currently in reset.
- `usb_suspend`  out  1  state is SUSPENDED.
- `lsm_state`  out  2  FSM state.
- `frameno`  out  11  last received frame number.
- `sof_miss_cnt`  out  8  saturating missed/erroneous SOF count.
- `evt_pend`  out  5  sticky events.
- `irq`  out  1  `|(evt_pend & irq_mask)`.

## Operation
- **Line decode:**
  - SE0 = !dp & !dn; J = dp & !dn; K = !dp & dn.
  - SE1 counts as activity and feeds no timer.
- **Reset timer:**
  - Counts consecutive SE0 cycles and saturates at `RESET_CYC`.
  - Any non-SE0 cycle zeroes it.
  - `usb_reset` = timer at threshold.
- **Idle timer:**
  - Counts cycles with J & !tx_active.
  - Any other cycle zeroes it.
  - Saturates at `SUSPEND_CYC`.
- **FSM states:** ACTIVE=0, SUSPENDED=1, RESUMING=2, RESET=3.
  - Any state → RESET when the reset timer reaches threshold; this has highest priority.
  - RESET → ACTIVE on the first non-SE0 cycle.
  - ACTIVE → SUSPENDED when the idle timer reaches threshold.
  - SUSPENDED → RESUMING on the first K cycle.
  - RESUMING → ACTIVE on the first SE0 cycle (host end-of-resume EOP), if no reset has occurred.
- **SOF:**
  - `sof_stb` loads `frameno` and zeroes the SOF watchdog.
  - If a prior SOF has been seen since reset and `sof_frameno` ≠ `frameno`+1 mod 2048, increment `sof_miss_cnt` and raise the ERR event.
  - Watchdog counts only in ACTIVE and is zeroed in every other state.
  - At `SOF_TMO_CYC` the watchdog increments `sof_miss_cnt`, raises ERR and restarts from 0.
  - `sof_miss_cnt` saturates at 255.
  - Entering RESET zeroes `sof_miss_cnt` and the seen-flag.
- **Events:**
  - Bit 0 RESET: entry to RESET.
  - Bit 1 SUSPEND: entry to SUSPENDED.
  - Bit 2 RESUME: entry to RESUMING.
  - Bit 3 SOF: every `sof_stb`.
  - Bit 4 ERR.
  - Set and clear of the same bit in one cycle: set wins.

## Timing
- **Reset values:**
  - `lsm_state`=ACTIVE.
  - `usb_reset`=0, `usb_suspend`=0.
  - `frameno`=0, `sof_miss_cnt`=0.
  - `evt_pend`=5'b00001 (reset pending after power-up).
  - `irq` = `irq_mask[0]`.
  - All timers 0.
- **Outputs:** all registered; `irq` is combinational from `evt_pend` and `irq_mask`.
- **Thresholds:**
  - `usb_reset` and `lsm_state`=RESET are visible after the edge ending the `RESET_CYC`-th consecutive SE0 cycle.
  - Likewise for suspend after `SUSPEND_CYC` idle cycles.
- **Single-cycle line transitions:** FSM and event bit update one edge after the qualifying line cycle.
- **`sof_stb`:** `frameno`, `evt_pend[3]` and the ERR check update on the next edge.
- **Same cycle:** a watchdog expiry and a bad-frame `sof_stb` together add exactly 1 to `sof_miss_cnt`.
- **Mid-operation reset:** `rst_n` low at any point returns all state to reset values immediately.

## Structure
- **`usb_lsm_pkg`:** FSM state encodings and event bit indices (EV_RESET..EV_ERR).
- **`usb_lsm_timer`:** saturating threshold counter with clear/enable/`hit`, parameterised by width and threshold; instantiated three times (reset, idle, SOF watchdog).

## Test plan
Bench parameters: `RESET_CYC`=8, `SUSPEND_CYC`=64, `SOF_TMO_CYC`=32.
- Release `rst_n` → `evt_pend`=00001, `lsm_state`=0; `evt_clr`=00001 → `evt_pend`=0.
- 7 SE0 cycles then J → no reset. 8 SE0 cycles → `usb_reset`=1, state 3, `evt_pend[0]`=1. J → state 0 the next edge.
- 64 idle J cycles → state 1, `usb_suspend`=1, `evt_pend[1]`. K → state 2, `evt_pend[2]`. SE0 → state 0.
- SOFs with frames 2046, 2047, 0 → no ERR, `frameno`=0. Then frame 5 → `sof_miss_cnt`=1, `evt_pend[4]`=1.
- ACTIVE with J/K activity and no SOF for 96 cycles → `sof_miss_cnt`=3. 300 expiries → saturates at 255. A reset then zeroes it.
- `evt_clr[3]` asserted in the same cycle as `sof_stb` → `evt_pend[3]` stays 1. `irq_mask`=01000 → `irq`=1; mask 0 → `irq`=0.

Source files
------------

// File: rtl/usb_lsm_pkg.sv
// Shared definitions for the USB line-state monitor: FSM encodings and
// event-pending bit positions.
package usb_lsm_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_SUSPENDED = 2'd1,
    ST_RESUMING  = 2'd2,
    ST_RESET     = 2'd3
  } lsm_state_e;

  localparam int unsigned EV_RESET   = 0;
  localparam int unsigned EV_SUSPEND = 1;
  localparam int unsigned EV_RESUME  = 2;
  localparam int unsigned EV_SOF     = 3;
  localparam int unsigned EV_ERR     = 4;
  localparam int unsigned EV_W       = 5;

  // A bus reset is assumed to have happened before power-up.
  localparam logic [EV_W-1:0] EVT_PEND_POR = 5'b00001;

endpackage

// File: rtl/usb_linestate_mon_if.sv
// Signal bundle between the USB core (PHY/RX decoder/CSR side) and the
// line-state monitor.
interface usb_linestate_mon_if;
  logic        rx_dp;
  logic        rx_dn;
  logic        tx_active;
  logic        sof_stb;
  logic [10:0] sof_frameno;
  logic [4:0]  evt_clr;
  logic [4:0]  irq_mask;
  logic        usb_reset;
  logic        usb_suspend;
  logic [1:0]  lsm_state;
  logic [10:0] frameno;
  logic [7:0]  sof_miss_cnt;
  logic [4:0]  evt_pend;
  logic        irq;

  modport master (
    output rx_dp, rx_dn, tx_active, sof_stb, sof_frameno, evt_clr, irq_mask,
    input  usb_reset, usb_suspend, lsm_state, frameno, sof_miss_cnt, evt_pend, irq
  );

  modport slave (
    input  rx_dp, rx_dn, tx_active, sof_stb, sof_frameno, evt_clr, irq_mask,
    output usb_reset, usb_suspend, lsm_state, frameno, sof_miss_cnt, evt_pend, irq
  );
endinterface

// File: rtl/usb_lsm_timer.sv
// Saturating threshold counter. expire_o flags the cycle whose count lands on
// THRESH; hit_o is the registered "count is at THRESH" state.
module usb_lsm_timer #(
  parameter int unsigned W      = 8,
  parameter int unsigned THRESH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o,
  output logic expire_o
);
  localparam logic [W-1:0] THR    = W'(THRESH);
  localparam logic [W-1:0] THR_M1 = W'(THRESH - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign hit_o    = (cnt_q == THR);
  assign expire_o = en_i && (cnt_q == THR_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != THR))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/usb_linestate_mon.sv
// USB full-speed bus-condition monitor: bus reset / suspend / resume FSM,
// SOF frame-continuity and lost-SOF watchdog, sticky events with one IRQ.
module usb_linestate_mon #(
  parameter int unsigned RESET_CYC   = 120,
  parameter int unsigned SUSPEND_CYC = 144000,
  parameter int unsigned SOF_TMO_CYC = 72000,
  parameter int unsigned CNT_W       = $clog2(SUSPEND_CYC + 1)
) (
  input logic                clk,
  input logic                rst_n,
  usb_linestate_mon_if.slave bus
);
  import usb_lsm_pkg::*;

  lsm_state_e       state_q, state_d;
  logic [10:0]      frameno_q, frameno_d;
  logic [7:0]       miss_q, miss_d;
  logic             seen_q, seen_d;
  logic [EV_W-1:0]  pend_q, pend_d, evt_set;

  logic se0, line_j, line_k;
  logic rst_hit, rst_expire, idle_hit, idle_expire, wd_hit, wd_expire, wd_fire;
  logic enter_reset, bad_frame, err;

  // SE1 is neither SE0 nor J/K: it clears both line timers.
  assign se0    = !bus.rx_dp && !bus.rx_dn;
  assign line_j =  bus.rx_dp && !bus.rx_dn;
  assign line_k = !bus.rx_dp &&  bus.rx_dn;

  usb_lsm_timer #(.W(CNT_W), .THRESH(RESET_CYC)) u_rst_tmr (
    .clk(clk), .rst_n(rst_n), .clr_i(!se0), .en_i(se0),
    .hit_o(rst_hit), .expire_o(rst_expire)
  );

  usb_lsm_timer #(.W(CNT_W), .THRESH(SUSPEND_CYC)) u_idle_tmr (
    .clk(clk), .rst_n(rst_n), .clr_i(!(line_j && !bus.tx_active)),
    .en_i(line_j && !bus.tx_active),
    .hit_o(idle_hit), .expire_o(idle_expire)
  );

  // Watchdog restarts itself on expiry, so it fires once per SOF_TMO_CYC.
  assign wd_fire = wd_expire || wd_hit;

  usb_lsm_timer #(.W(CNT_W), .THRESH(SOF_TMO_CYC)) u_wd_tmr (
    .clk(clk), .rst_n(rst_n),
    .clr_i(bus.sof_stb || (state_q != ST_ACTIVE) || wd_fire),
    .en_i(state_q == ST_ACTIVE),
    .hit_o(wd_hit), .expire_o(wd_expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACTIVE:    if (idle_expire || idle_hit) state_d = ST_SUSPENDED;
      ST_SUSPENDED: if (line_k)                  state_d = ST_RESUMING;
      ST_RESUMING:  if (se0)                     state_d = ST_ACTIVE;
      ST_RESET:     if (!se0)                    state_d = ST_ACTIVE;
      default:                                   state_d = ST_ACTIVE;
    endcase
    if (rst_expire) state_d = ST_RESET;
  end

  assign enter_reset = (state_d == ST_RESET) && (state_q != ST_RESET);
  assign bad_frame   = bus.sof_stb && seen_q && (bus.sof_frameno != frameno_q + 11'd1);
  assign err         = bad_frame || wd_fire;

  always_comb begin
    frameno_d = bus.sof_stb ? bus.sof_frameno : frameno_q;
    seen_d    = seen_q || bus.sof_stb;
    miss_d    = miss_q;
    if (err && (miss_q != 8'hFF)) miss_d = miss_q + 8'd1;
    if (enter_reset) begin
      seen_d = 1'b0;
      miss_d = '0;
    end

    evt_set              = '0;
    evt_set[EV_RESET]    = enter_reset;
    evt_set[EV_SUSPEND]  = (state_d == ST_SUSPENDED) && (state_q != ST_SUSPENDED);
    evt_set[EV_RESUME]   = (state_d == ST_RESUMING)  && (state_q != ST_RESUMING);
    evt_set[EV_SOF]      = bus.sof_stb;
    evt_set[EV_ERR]      = err;
    pend_d = (pend_q & ~bus.evt_clr) | evt_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACTIVE;
      frameno_q <= '0;
      miss_q    <= '0;
      seen_q    <= 1'b0;
      pend_q    <= EVT_PEND_POR;
    end else begin
      state_q   <= state_d;
      frameno_q <= frameno_d;
      miss_q    <= miss_d;
      seen_q    <= seen_d;
      pend_q    <= pend_d;
    end
  end

  assign bus.usb_reset    = rst_hit;
  assign bus.usb_suspend  = (state_q == ST_SUSPENDED);
  assign bus.lsm_state    = state_q;
  assign bus.frameno      = frameno_q;
  assign bus.sof_miss_cnt = miss_q;
  assign bus.evt_pend     = pend_q;
  assign bus.irq          = |(pend_q & bus.irq_mask);
endmodule
